regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates between two write-back requesters, the ALU and the memory/load unit, over valid/ready handshakes.
- Keeps a per-register pending scoreboard and drives a decode stall for RAW and WAW hazards.
- Sits between the execute/memory stages and the register file write inputs (writeReg, writeAddress, writeData).

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width (2**ADDR_W registers)
STARVE_LIMIT, 4, consecutive ALU-blocked cycles before the ALU is forced to win one grant (legal range 1..15)

Ports:
ck  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU write-back request
alu_ready  output  1  ALU request accepted this cycle
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load write-back request
mem_ready  output  1  load request accepted this cycle
mem_addr  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
iss_valid  input  1  decode issuing an instruction that writes iss_addr
iss_addr  input  ADDR_W  destination of issuing instruction
iss_ready  output  1  issue accepted (no WAW conflict)
rs1, rs2  input  ADDR_W each  source registers of the instruction in decode
stall  output  1  a source register is pending (RAW)
writeReg  output  1  register file write enable
writeAddress  output  ADDR_W  register file write address
writeData  output  DATA_W  register file write data

Behaviour:
- Reset (rst=1 at posedge):
  - writeReg=0, writeAddress=0, writeData=0.
  - All pending bits clear; starvation counter=0.
  - Reset mid-request drops all in-flight requests; nothing is written.
- Handshakes:
  - alu_ready and mem_ready are combinational from valids and the starvation counter.
  - A transfer occurs when valid&&ready at a posedge.
  - At most one of alu_ready/mem_ready is 1 per cycle.
  - Requesters hold valid, addr and data stable until accepted.
- Arbitration:
  - Only mem_valid: mem_ready=1.
  - Only alu_valid: alu_ready=1.
  - Both valid: mem wins, unless starve_cnt==STARVE_LIMIT, in which case alu wins.
- Starvation counter:
  - Increments on each cycle with alu_valid=1 and alu_ready=0, saturating at STARVE_LIMIT.
  - Cleared on any ALU transfer.
- Write port:
  - Registered, 1-cycle latency. The cycle after a transfer, writeReg=1 with the accepted addr/data; otherwise writeReg=0.
  - writeAddress/writeData hold their last values when writeReg=0.
  - Register 0: a transfer with addr==0 is accepted, but writeReg stays 0 the next cycle.
- Scoreboard (pending[2**ADDR_W-1:0]):
  - iss_ready = !(iss_valid && pending[iss_addr] && iss_addr!=0).
  - On iss_valid&&iss_ready with iss_addr!=0, set pending[iss_addr].
  - When writeReg=1 at a posedge, clear pending[writeAddress].
  - Same register set and cleared at the same edge: set wins (the new writer is still outstanding).
  - pending[0] is always 0.
- Stall:
  - stall = pending[rs1] | pending[rs2] (combinational).
  - Stall deasserts the cycle after writeReg=1 for that register, i.e. once the data is readable from the register file.
- Write-backs to a non-pending register are legal and written; no error flag is raised.

Test Plan:
- Reset: apply rst=1 for 2 cycles with alu_valid=mem_valid=1 -> alu_ready=mem_ready granted per rule but writeReg=0 during and on the first cycle after reset; pending=0 and stall=0.
- Single ALU write: iss r5; alu_valid, addr=5, data=0xDEADBEEF -> accepted in the same cycle; next cycle writeReg=1, writeAddress=5, writeData=0xDEADBEEF; stall with rs1=5 high from issue until the cycle after writeReg.
- Contention and starvation with STARVE_LIMIT=4: alu_valid and mem_valid held continuously with fresh mem data each cycle -> mem granted 4 cycles, ALU granted on the 5th, counter returns to 0, then mem again.
- r0 write: mem_valid, addr=0, data=0x1234 -> mem_ready=1, writeReg stays 0; iss_addr=0 never raises stall or drops iss_ready.
- WAW and same-edge case:
  - With r7 pending, iss_valid r7 -> iss_ready=0.
  - In the cycle writeReg=1 for r7, iss r7 again -> pending[7] remains 1 afterwards.
- Back-to-back: alu to r3 then mem to r4 on consecutive cycles -> writeReg=1 on two consecutive cycles with addresses 3 then 4; both pending bits clear.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the ALU/load requesters, the decode stage and the
// register-file write port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_ready;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              stall;
  logic              writeReg;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] writeData;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  iss_valid, iss_addr, rs1, rs2,
    output alu_ready, mem_ready, iss_ready, stall,
    output writeReg, writeAddress, writeData
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output iss_valid, iss_addr, rs1, rs2,
    input  alu_ready, mem_ready, iss_ready, stall,
    input  writeReg, writeAddress, writeData
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port owner: ALU/load write-back arbitration with
// starvation guard, pending-register scoreboard and decode stall.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  ck,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic alu_ready_c, mem_ready_c, iss_ready_c;
  logic alu_xfer, mem_xfer;

  always_comb begin
    alu_ready_c = bus.alu_valid && (!bus.mem_valid || starve_q == LIMIT);
    mem_ready_c = bus.mem_valid && !alu_ready_c;
    iss_ready_c = !(bus.iss_valid && pending_q[bus.iss_addr] && bus.iss_addr != '0);
    alu_xfer    = bus.alu_valid && alu_ready_c;
    mem_xfer    = bus.mem_valid && mem_ready_c;
  end

  assign bus.alu_ready    = alu_ready_c;
  assign bus.mem_ready    = mem_ready_c;
  assign bus.iss_ready    = iss_ready_c;
  assign bus.stall        = pending_q[bus.rs1] | pending_q[bus.rs2];
  assign bus.writeReg     = we_q;
  assign bus.writeAddress = waddr_q;
  assign bus.writeData    = wdata_q;

  always_comb begin
    starve_d  = starve_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;

    if (alu_xfer) begin
      starve_d = '0;
    end else if (bus.alu_valid && starve_q < LIMIT) begin
      starve_d = starve_q + 4'd1;
    end

    // r0 transfers are accepted but leave the write port and its held values untouched.
    if (alu_xfer && bus.alu_addr != '0) begin
      we_d    = 1'b1;
      waddr_d = bus.alu_addr;
      wdata_d = bus.alu_data;
    end else if (mem_xfer && bus.mem_addr != '0) begin
      we_d    = 1'b1;
      waddr_d = bus.mem_addr;
      wdata_d = bus.mem_data;
    end

    // Clear before set so a same-edge reissue keeps the register pending.
    if (we_q) begin
      pending_d[waddr_q] = 1'b0;
    end
    if (bus.iss_valid && iss_ready_c && bus.iss_addr != '0) begin
      pending_d[bus.iss_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      starve_q  <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, starvation,
// r0 writes, WAW / same-edge scoreboard and back-to-back write-backs.
module tb_regfile_wb_arbiter;
  logic ck;
  logic rst;
  int   nvec;
  int   nerr;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .STARVE_LIMIT(4)
  ) dut (
    .ck (ck),
    .rst(rst),
    .bus(bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_addr  = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h1111_1111;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 32'h2222_2222;
    for (int i = 0; i < 2; i++) begin
      tick();
      nvec++;
      if (bus.writeReg !== 1'b0) begin nerr++; $display("FAIL rst_we[%0d]: got %b want 0", i, bus.writeReg); end
      nvec++;
      if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
        nerr++; $display("FAIL rst_grant[%0d]: got alu=%b mem=%b want alu=0 mem=1", i, bus.alu_ready, bus.mem_ready);
      end
    end
    rst = 1'b0;
    idle();
    bus.rs1 = 5'd3; bus.rs2 = 5'd4;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
    #1;
    nvec++;
    if (bus.writeAddress !== 5'd0 || bus.writeData !== 32'h0) begin
      nerr++; $display("FAIL rst_wport: got addr=%0d data=%h want 0/0", bus.writeAddress, bus.writeData);
    end
    nvec++;
    if (bus.stall !== 1'b0 || bus.iss_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_sb: got stall=%b iss_ready=%b want 0/1", bus.stall, bus.iss_ready);
    end
    bus.iss_valid = 1'b0;
    tick();
    nvec++;
    if (bus.writeReg !== 1'b0) begin nerr++; $display("FAIL rst_after_we: got %b want 0", bus.writeReg); end
  endtask

  task automatic test_single_alu();
    idle();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd5; bus.rs1 = 5'd5;
    #1;
    nvec++;
    if (bus.iss_ready !== 1'b1 || bus.stall !== 1'b0) begin
      nerr++; $display("FAIL alu_issue: got iss_ready=%b stall=%b want 1/0", bus.iss_ready, bus.stall);
    end
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    #1;
    nvec++;
    if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0 || bus.stall !== 1'b1) begin
      nerr++; $display("FAIL alu_accept: got alu=%b mem=%b stall=%b want 1/0/1", bus.alu_ready, bus.mem_ready, bus.stall);
    end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    nvec++;
    if (bus.writeReg !== 1'b1 || bus.writeAddress !== 5'd5 || bus.writeData !== 32'hDEAD_BEEF) begin
      nerr++; $display("FAIL alu_wb: got we=%b addr=%0d data=%h want 1/5/deadbeef", bus.writeReg, bus.writeAddress, bus.writeData);
    end
    nvec++;
    if (bus.stall !== 1'b1) begin nerr++; $display("FAIL alu_stall_wb: got %b want 1", bus.stall); end
    tick();
    nvec++;
    if (bus.writeReg !== 1'b0 || bus.writeAddress !== 5'd5 || bus.stall !== 1'b0) begin
      nerr++; $display("FAIL alu_after: got we=%b addr=%0d stall=%b want 0/5/0", bus.writeReg, bus.writeAddress, bus.stall);
    end
  endtask

  task automatic test_starvation();
    logic        exp_alu;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    idle();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd6; bus.alu_data = 32'h0000_A1A1;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd10;
    for (int i = 0; i < 6; i++) begin
      bus.mem_data = 32'h100 + 32'(i);
      exp_alu  = (i == 4);
      exp_addr = exp_alu ? 5'd6 : 5'd10;
      exp_data = exp_alu ? 32'h0000_A1A1 : 32'h100 + 32'(i);
      #1;
      nvec++;
      if (bus.alu_ready !== exp_alu || bus.mem_ready !== !exp_alu) begin
        nerr++; $display("FAIL starve_grant[%0d]: got alu=%b mem=%b want alu=%b", i, bus.alu_ready, bus.mem_ready, exp_alu);
      end
      tick();
      nvec++;
      if (bus.writeReg !== 1'b1 || bus.writeAddress !== exp_addr || bus.writeData !== exp_data) begin
        nerr++; $display("FAIL starve_wb[%0d]: got we=%b addr=%0d data=%h want 1/%0d/%h",
                         i, bus.writeReg, bus.writeAddress, bus.writeData, exp_addr, exp_data);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_r0();
    idle();
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 32'h1234;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
    #1;
    nvec++;
    if (bus.mem_ready !== 1'b1 || bus.iss_ready !== 1'b1 || bus.stall !== 1'b0) begin
      nerr++; $display("FAIL r0_accept: got mem=%b iss_ready=%b stall=%b want 1/1/0", bus.mem_ready, bus.iss_ready, bus.stall);
    end
    tick();
    bus.mem_valid = 1'b0;
    #1;
    nvec++;
    if (bus.writeReg !== 1'b0 || bus.writeAddress !== 5'd10 || bus.writeData !== 32'h105) begin
      nerr++; $display("FAIL r0_wb: got we=%b addr=%0d data=%h want 0/10/105", bus.writeReg, bus.writeAddress, bus.writeData);
    end
    nvec++;
    if (bus.iss_ready !== 1'b1 || bus.stall !== 1'b0) begin
      nerr++; $display("FAIL r0_reissue: got iss_ready=%b stall=%b want 1/0", bus.iss_ready, bus.stall);
    end
    idle();
    tick();
  endtask

  task automatic test_waw();
    idle();
    bus.rs1 = 5'd7;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
    tick();
    nvec++;
    if (bus.iss_ready !== 1'b0 || bus.stall !== 1'b1) begin
      nerr++; $display("FAIL waw_block: got iss_ready=%b stall=%b want 0/1", bus.iss_ready, bus.stall);
    end
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h77;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    nvec++;
    if (bus.writeReg !== 1'b1 || bus.writeAddress !== 5'd7) begin
      nerr++; $display("FAIL waw_wb: got we=%b addr=%0d want 1/7", bus.writeReg, bus.writeAddress);
    end
    tick();
    nvec++;
    if (bus.stall !== 1'b0) begin nerr++; $display("FAIL waw_clear: got stall=%b want 0", bus.stall); end
    // Unscoreboarded write to r7, then reissue r7 in its writeReg cycle.
    bus.alu_valid = 1'b1; bus.alu_data = 32'h78;
    tick();
    bus.alu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
    #1;
    nvec++;
    if (bus.writeReg !== 1'b1 || bus.iss_ready !== 1'b1) begin
      nerr++; $display("FAIL same_edge_issue: got we=%b iss_ready=%b want 1/1", bus.writeReg, bus.iss_ready);
    end
    tick();
    bus.iss_valid = 1'b0;
    #1;
    nvec++;
    if (bus.stall !== 1'b1) begin nerr++; $display("FAIL same_edge_pending: got stall=%b want 1", bus.stall); end
    bus.alu_valid = 1'b1; bus.alu_data = 32'h79;
    tick();
    bus.alu_valid = 1'b0;
    tick();
    nvec++;
    if (bus.stall !== 1'b0) begin nerr++; $display("FAIL same_edge_drain: got stall=%b want 0", bus.stall); end
  endtask

  task automatic test_back_to_back();
    idle();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
    tick();
    bus.iss_addr = 5'd4;
    tick();
    bus.iss_valid = 1'b0;
    bus.rs1 = 5'd3; bus.rs2 = 5'd4;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h33;
    #1;
    nvec++;
    if (bus.stall !== 1'b1 || bus.alu_ready !== 1'b1) begin
      nerr++; $display("FAIL b2b_alu: got stall=%b alu_ready=%b want 1/1", bus.stall, bus.alu_ready);
    end
    tick();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 32'h44;
    #1;
    nvec++;
    if (bus.mem_ready !== 1'b1 || bus.writeReg !== 1'b1 || bus.writeAddress !== 5'd3 || bus.writeData !== 32'h33) begin
      nerr++; $display("FAIL b2b_wb3: got mem_ready=%b we=%b addr=%0d data=%h want 1/1/3/33",
                       bus.mem_ready, bus.writeReg, bus.writeAddress, bus.writeData);
    end
    tick();
    bus.mem_valid = 1'b0;
    #1;
    nvec++;
    if (bus.writeReg !== 1'b1 || bus.writeAddress !== 5'd4 || bus.writeData !== 32'h44 || bus.stall !== 1'b1) begin
      nerr++; $display("FAIL b2b_wb4: got we=%b addr=%0d data=%h stall=%b want 1/4/44/1",
                       bus.writeReg, bus.writeAddress, bus.writeData, bus.stall);
    end
    tick();
    nvec++;
    if (bus.writeReg !== 1'b0 || bus.stall !== 1'b0) begin
      nerr++; $display("FAIL b2b_done: got we=%b stall=%b want 0/0", bus.writeReg, bus.stall);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    idle();
    test_reset();
    test_single_alu();
    test_starvation();
    test_r0();
    test_waw();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
